// File: rtl/bintobcd_pkg.sv
// Shared constants and sizing helper for the binary-to-BCD converter.
package bintobcd_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned ADD3_THRESH     = 5;
  localparam int unsigned SINGLE_DIGIT_MAX = 9;

  // 2^w is never a power of ten, so digits(2^w - 1) = floor(w*log10(2)) + 1.
  function automatic int unsigned digits_needed(input int unsigned width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bintobcd_core.sv
// Combinational double-dabble for one channel; upper digits beyond WIDTH_OUT are dropped.
module bintobcd_core
  import bintobcd_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = 4,
  parameter int unsigned WIDTH_OUT = 8
) (
  input  logic [WIDTH_IN-1:0]  bin_i,
  output logic [WIDTH_OUT-1:0] bcd_o
);

  localparam int unsigned NDIG = WIDTH_OUT / DIGIT_W;

  logic [WIDTH_OUT-1:0] acc;
  logic [WIDTH_OUT-1:0] rot;
  logic [WIDTH_IN-1:0]  src;
  logic [DIGIT_W-1:0]   nib;

  always_comb begin
    acc = '0;
    rot = '0;
    nib = '0;
    src = bin_i;
    for (int unsigned j = 0; j < WIDTH_IN; j++) begin
      // Walk the nibbles by rotating right one digit at a time so every
      // select stays constant; after NDIG rotations the order is restored.
      rot = acc;
      for (int unsigned k = 0; k < NDIG; k++) begin
        nib = rot[DIGIT_W-1:0];
        if (nib >= DIGIT_W'(ADD3_THRESH))
          nib = nib + DIGIT_W'(3);
        rot = (rot >> DIGIT_W) | (WIDTH_OUT'(nib) << (WIDTH_OUT - DIGIT_W));
      end
      acc = (rot << 1) | WIDTH_OUT'(src[WIDTH_IN-1]);
      src = src << 1;
    end
    bcd_o = acc;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Dual-channel registered binary-to-BCD converter, 1-cycle latency.
// Optional err_1/err_2 (input > 9) enabled by defining BINTOBCD_ERR_EN.
module bin_to_bcd
  import bintobcd_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = 4,
  parameter int unsigned WIDTH_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  bin_1,
  input  logic [WIDTH_IN-1:0]  bin_2,
  output logic                 out_valid,
  output logic [WIDTH_OUT-1:0] bcd_1,
  output logic [WIDTH_OUT-1:0] bcd_2
`ifdef BINTOBCD_ERR_EN
  ,
  output logic                 err_1,
  output logic                 err_2
`endif
);

  if (WIDTH_OUT % DIGIT_W != 0) begin : g_bad_width
    $error("bin_to_bcd: WIDTH_OUT must be a multiple of 4");
  end

  if (digits_needed(WIDTH_IN) > WIDTH_OUT / DIGIT_W) begin : g_truncated
    $warning("bin_to_bcd: WIDTH_OUT too small, upper decimal digits are discarded");
  end

  logic [WIDTH_OUT-1:0] bcd1_d, bcd2_d;
  logic [WIDTH_OUT-1:0] bcd1_q, bcd2_q;
  logic                 valid_q;

  bintobcd_core #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_core_1 (
    .bin_i (bin_1),
    .bcd_o (bcd1_d)
  );

  bintobcd_core #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT)) u_core_2 (
    .bin_i (bin_2),
    .bcd_o (bcd2_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd1_q  <= '0;
      bcd2_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        bcd1_q <= bcd1_d;
        bcd2_q <= bcd2_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign bcd_1     = bcd1_q;
  assign bcd_2     = bcd2_q;

`ifdef BINTOBCD_ERR_EN
  logic err1_d, err2_d;
  logic err1_q, err2_q;

  assign err1_d = (32'(bin_1) > SINGLE_DIGIT_MAX);
  assign err2_d = (32'(bin_2) > SINGLE_DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else if (in_valid) begin
      err1_q <= err1_d;
      err2_q <= err2_d;
    end
  end

  assign err_1 = err1_q;
  assign err_2 = err2_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed, table-driven self-checking bench for bin_to_bcd (default 4 -> 8).
module tb_bin_to_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] bin_1, bin_2;
  logic       out_valid;
  logic [7:0] bcd_1, bcd_2;
`ifdef BINTOBCD_ERR_EN
  logic       err_1, err_2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd #(.WIDTH_IN(4), .WIDTH_OUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bin_1     (bin_1),
    .bin_2     (bin_2),
    .out_valid (out_valid),
    .bcd_1     (bcd_1),
    .bcd_2     (bcd_2)
`ifdef BINTOBCD_ERR_EN
    ,
    .err_1     (err_1),
    .err_2     (err_2)
`endif
  );

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       er1;
    logic       er2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    rst = r; in_valid = v; bin_1 = a; bin_2 = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  initial begin
    vecs[0] = '{4'd3,  4'd7,  8'h03, 8'h07, 1'b0, 1'b0};
    vecs[1] = '{4'd8,  4'd9,  8'h08, 8'h09, 1'b0, 1'b0};
    vecs[2] = '{4'd10, 4'd15, 8'h10, 8'h15, 1'b1, 1'b1};
    vecs[3] = '{4'd0,  4'd0,  8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{4'd15, 4'd1,  8'h15, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{4'd12, 4'd5,  8'h12, 8'h05, 1'b1, 1'b0};
    vecs[6] = '{4'd11, 4'd13, 8'h11, 8'h13, 1'b1, 1'b1};
    vecs[7] = '{4'd14, 4'd4,  8'h14, 8'h04, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; bin_1 = '0; bin_2 = '0;
    #2;

    // Reset with arbitrary live inputs: rst must dominate in_valid.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'd9, 4'd14);
      check("rst_bcd_1", 32'(bcd_1), 32'h00);
      check("rst_bcd_2", 32'(bcd_2), 32'h00);
      check("rst_valid", 32'(out_valid), 32'd0);
    end

    // Table vectors, applied back-to-back.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, vecs[i].b1, vecs[i].b2);
      check($sformatf("vec%0d_bcd_1", i), 32'(bcd_1), 32'(vecs[i].e1));
      check($sformatf("vec%0d_bcd_2", i), 32'(bcd_2), 32'(vecs[i].e2));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
`ifdef BINTOBCD_ERR_EN
      check($sformatf("vec%0d_err_1", i), 32'(err_1), 32'(vecs[i].er1));
      check($sformatf("vec%0d_err_2", i), 32'(err_2), 32'(vecs[i].er2));
`endif
    end

    // Exhaustive 0..9 x 0..9 sweep, one pair per cycle.
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        step(1'b0, 1'b1, 4'(a), 4'(b));
        check($sformatf("sweep_%0d_%0d_bcd_1", a, b), 32'(bcd_1), 32'(to_bcd(a)));
        check($sformatf("sweep_%0d_%0d_bcd_2", a, b), 32'(bcd_2), 32'(to_bcd(b)));
        check($sformatf("sweep_%0d_%0d_valid", a, b), 32'(out_valid), 32'd1);
`ifdef BINTOBCD_ERR_EN
        check($sformatf("sweep_%0d_%0d_err_1", a, b), 32'(err_1), 32'd0);
        check($sformatf("sweep_%0d_%0d_err_2", a, b), 32'(err_2), 32'd0);
`endif
      end
    end

    // Hold: capture 5, then drop in_valid while inputs keep changing.
    step(1'b0, 1'b1, 4'd5, 4'd2);
    check("hold_load_bcd_1", 32'(bcd_1), 32'h05);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'(11 + i), 4'(7 - i));
      check($sformatf("hold%0d_bcd_1", i), 32'(bcd_1), 32'h05);
      check($sformatf("hold%0d_bcd_2", i), 32'(bcd_2), 32'h02);
      check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd0);
    end

    // Reset mid-stream: an accepted 6 colliding with rst never emerges.
    step(1'b0, 1'b1, 4'd4, 4'd3);
    check("pre_rst_bcd_1", 32'(bcd_1), 32'h04);
    step(1'b1, 1'b1, 4'd6, 4'd6);
    check("midrst_bcd_1", 32'(bcd_1), 32'h00);
    check("midrst_bcd_2", 32'(bcd_2), 32'h00);
    check("midrst_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b0, 4'd6, 4'd6);
    check("postrst_bcd_1", 32'(bcd_1), 32'h00);
    check("postrst_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 4'd6, 4'd13);
    check("newin_bcd_1", 32'(bcd_1), 32'h06);
    check("newin_bcd_2", 32'(bcd_2), 32'h13);
    check("newin_valid", 32'(out_valid), 32'd1);

    // Valid result followed by reset clears it.
    step(1'b1, 1'b0, 4'd0, 4'd0);
    check("clr_bcd_1", 32'(bcd_1), 32'h00);
    check("clr_bcd_2", 32'(bcd_2), 32'h00);
`ifdef BINTOBCD_ERR_EN
    check("clr_err_2", 32'(err_2), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
